sbox_byte_serial: RTL and testbench

- Byte-serial SubBytes engine that sits directly upstream of the bit-level `Sbox` netlist.
- Loads a full state of NBYTES bytes and feeds one byte per clock into a single `Sbox` instance.
- Shifts each substituted byte back into the state register. After NBYTES cycles it presents the whole substituted state with a done pulse.
- Used as the round-level SubBytes stage of the serial AES datapath on our FPGA.

---
 rtl/sbox_byte_serial_pkg.sv | 18 +
 rtl/MyMUXn.sv | 13 +
 rtl/MyRegn.sv | 23 ++
 rtl/Sbox.sv | 51 +++++
 rtl/sbox_byte_serial.sv | 135 +++++++++++++
 tb/tb_sbox_byte_serial.sv | 208 ++++++++++++++++++++
 6 files changed

// File: rtl/sbox_byte_serial_pkg.sv
// Shared types and constants for the byte-serial SubBytes engine.
package sbox_byte_serial_pkg;

  // Width of one state byte.
  localparam int BYTE_W = 8;

  // Engine sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // FIPS-197 Appendix C.1 plaintext and its SubBytes image.
  localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FIPS_OUT = 128'h638293C31BFC33F5C4EEACEA4BC12816;

endpackage

// File: rtl/MyMUXn.sv
// N-bit two-input multiplexer: sel=0 passes a, sel=1 passes b.
module MyMUXn #(
  parameter int N = 8
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/MyRegn.sv
// N-bit datapath register with synchronous clear and load enable.
module MyRegn #(
  parameter int N = 8
) (
  input  logic         C,
  input  logic         RST,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Capture d when enabled; clear on reset.
  always_ff @(posedge C) begin
    if (RST) begin
      q <= {N{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/Sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed
// by the affine transform. Purely combinational, no registers.
module Sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Full GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  assign y = affine(gf_inv(x));

endmodule

// File: rtl/sbox_byte_serial.sv
// Byte-serial SubBytes engine: loads a full state, rotates it byte by
// byte through a single Sbox, and presents the substituted state with
// a one-cycle done pulse.
module sbox_byte_serial
  import sbox_byte_serial_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int CW     = 4
) (
  input  logic                     C,
  input  logic                     RST,
  input  logic                     start,
  input  logic [8*NBYTES-1:0]      din,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  output logic [8*NBYTES-1:0]      dout
);

  localparam int W = BYTE_W * NBYTES;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e          state_r;
  logic [CW-1:0]   cnt_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;

  logic [W-1:0]    shift_r;
  logic [W-1:0]    dout_r;
  logic [W-1:0]    shifted_s;
  logic [W-1:0]    next_s;
  logic [7:0]      sbox_x_s;
  logic [7:0]      sbox_y_s;
  logic            load_s;
  logic            run_s;
  logic            last_s;
  logic            shift_en_s;

  // A start is taken only while the engine advertises ready (IDLE or DONE).
  assign load_s     = ((state_r == IDLE) || (state_r == DONE)) && start;
  assign run_s      = (state_r == RUN);
  assign last_s     = run_s && (cnt_r == LAST_CNT);
  assign shift_en_s = load_s | run_s;

  // Top byte feeds the Sbox; its image re-enters at the bottom so that
  // after NBYTES shifts every byte is back in its original slot.
  assign sbox_x_s  = shift_r[W-1 -: BYTE_W];
  assign shifted_s = {shift_r[W-BYTE_W-1:0], sbox_y_s};

  Sbox u_sbox (
    .x (sbox_x_s),
    .y (sbox_y_s)
  );

  MyMUXn #(.N(W)) u_load_mux (
    .sel (load_s),
    .a   (shifted_s),
    .b   (din),
    .y   (next_s)
  );

  MyRegn #(.N(W)) u_shift_reg (
    .C   (C),
    .RST (RST),
    .en  (shift_en_s),
    .d   (next_s),
    .q   (shift_r)
  );

  // dout takes the post-shift value on the final RUN cycle only.
  MyRegn #(.N(W)) u_dout_reg (
    .C   (C),
    .RST (RST),
    .en  (last_s),
    .d   (shifted_s),
    .q   (dout_r)
  );

  // Sequencer: state, byte counter and registered handshake outputs.
  always_ff @(posedge C) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          cnt_r  <= {CW{1'b0}};
          done_r <= 1'b0;
          if (start) begin
            state_r <= RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            cnt_r   <= cnt_r + CNT_ONE;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign dout  = dout_r;

endmodule

// File: tb/tb_sbox_byte_serial.sv
// Scoreboard bench for sbox_byte_serial (NBYTES=16).
module tb_sbox_byte_serial;
  import sbox_byte_serial_pkg::*;

  logic         C = 1'b0;
  logic         RST;
  logic         start;
  logic [127:0] din;
  logic         ready;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  sbox_byte_serial #(.NBYTES(16), .CW(4)) dut (
    .C     (C),
    .RST   (RST),
    .start (start),
    .din   (din),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 C = ~C;

  // Reference AES S-box (FIPS-197 Figure 7).
  logic [7:0] sbox_tab [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef struct {
    logic [127:0] val;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp  = 0;
  int           n_err  = 0;
  int           cyc    = 0;
  logic [127:0] hold_v = 128'd0;
  logic         rdy_prev = 1'b0;

  // Single comparison point: counts and reports mismatches.
  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[v[8*i +: 8]];
    return r;
  endfunction

  // Monitor: push on accepted start, pop and compare on done, check hold otherwise.
  always @(posedge C) begin : mon
    logic         acc;
    logic         rst_s;
    logic [127:0] din_s;
    exp_t         e;
    cyc   = cyc + 1;
    rst_s = RST;
    din_s = din;
    acc   = !RST && start && rdy_prev;
    #1;
    if (rst_s) begin
      sb_q.delete();
      hold_v = 128'd0;
      check_val("rst_dout", dout, 128'd0);
      check_val("rst_done", {127'd0, done}, 128'd0);
    end else if (done) begin
      if (sb_q.size() == 0) begin
        check_val("stray_done", {127'd0, done}, 128'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("dout", dout, e.val);
        check_val("latency", 128'(cyc), 128'(e.due));
        hold_v = e.val;
      end
    end else begin
      check_val("hold", dout, hold_v);
    end
    if (acc) begin
      e.val = ref_sub(din_s);
      e.due = cyc + 16;
      sb_q.push_back(e);
    end
    rdy_prev = ready;
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge C);
    if (sb_q.size() != 0) check_val("timeout", 128'(sb_q.size()), 128'd0);
    @(negedge C);
  endtask

  task automatic run_op(input logic [127:0] v);
    @(negedge C);
    din   = v;
    start = 1'b1;
    @(negedge C);
    start = 1'b0;
    din   = {$urandom(), $urandom(), $urandom(), $urandom()};
    check_val("run_busy", {127'd0, busy}, 128'd1);
    check_val("run_ready", {127'd0, ready}, 128'd0);
    wait_drain();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [127:0] b2b_a;
    logic [127:0] b2b_b;
    RST   = 1'b1;
    start = 1'b1;
    din   = FIPS_IN;
    repeat (2) @(negedge C);
    check_val("reset_ready", {127'd0, ready}, 128'd1);
    check_val("reset_busy",  {127'd0, busy},  128'd0);
    check_val("reset_done",  {127'd0, done},  128'd0);
    check_val("reset_dout",  dout, 128'd0);
    RST   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge C);
    check_val("idle_ready", {127'd0, ready}, 128'd1);
    check_val("idle_busy",  {127'd0, busy},  128'd0);

    // FIPS vector, checked against the published constant as well.
    run_op(FIPS_IN);
    check_val("fips_const", dout, FIPS_OUT);

    // Corner bytes.
    run_op({16{8'h00}});
    check_val("all00", dout, {16{8'h63}});
    run_op({16{8'hff}});
    check_val("allff", dout, {16{8'h16}});
    run_op({8'h53, {15{8'h01}}});
    check_val("b15_53", dout, {8'hed, {15{8'h7c}}});

    // Back-to-back with start held high; din junk during RUN.
    b2b_a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b2b_b = 128'hdeadbeefcafef00d0123456789abcdef;
    @(negedge C);
    din   = b2b_a;
    start = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge C);
      if (i == 18) begin
        start = 1'b0;
        din   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if (i < 11) begin
        din = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        din = b2b_b;
      end
    end
    wait_drain();
    check_val("b2b_second", dout, ref_sub(b2b_b));

    // Reset in the middle of an operation.
    @(negedge C);
    din   = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    start = 1'b1;
    @(negedge C);
    start = 1'b0;
    repeat (7) @(negedge C);
    RST = 1'b1;
    @(negedge C);
    RST = 1'b0;
    check_val("midrst_ready", {127'd0, ready}, 128'd1);
    check_val("midrst_busy",  {127'd0, busy},  128'd0);
    check_val("midrst_dout",  dout, 128'd0);
    repeat (20) @(negedge C);
    run_op(FIPS_IN);
    check_val("post_rst_fips", dout, FIPS_OUT);

    // Every byte value through the Sbox path.
    for (int v = 0; v < 256; v++) run_op({16{8'(v)}});

    check_val("pending", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
